// File: rtl/data_memory_ctrl_pkg.sv
// Shared definitions for the data memory controller: RV32 load/store size codes,
// FSM state encoding and the byte-strobe helper.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Only the low two funct3 bits carry the access size; the sign bit is irrelevant for strobes.
  function automatic logic [3:0] byte_strobe(input logic [2:0] funct3, input logic [1:0] lane);
    case (funct3[1:0])
      2'b00:   return 4'b0001 << lane;
      2'b01:   return 4'b0011 << lane;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between the LSU (master) and the data memory controller (slave).
// Handshake: a request transfers on a clk edge where req_valid && req_ready; the response
// is a single-cycle rsp_valid pulse with no backpressure, rsp_error/rsp_rdata qualified by it.
interface data_memory_ctrl_if #(
  parameter int ADDR_WIDTH = 32
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_error;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/data_memory_ctrl_lane_align.sv
// Combinational lane steering: extracts and extends load data from a RAM word and
// replicates store data across byte lanes so strobes can pick the right bytes.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] wdata_rep
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = word[8*lane +: 8];
    sel_half = lane[1] ? word[31:16] : word[15:0];
    rdata    = '0;
    case (funct3)
      F3_B:    rdata = {{24{sel_byte[7]}}, sel_byte};
      F3_H:    rdata = {{16{sel_half[15]}}, sel_half};
      F3_W:    rdata = word;
      F3_BU:   rdata = {24'd0, sel_byte};
      F3_HU:   rdata = {16'd0, sel_half};
      default: rdata = '0;
    endcase
  end

  always_comb begin
    case (funct3[1:0])
      2'b00:   wdata_rep = {4{wdata[7:0]}};
      2'b01:   wdata_rep = {2{wdata[15:0]}};
      default: wdata_rep = wdata;
    endcase
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Data memory controller: byte-addressed RV32 loads/stores onto a word RAM with
// configurable load latency, byte-strobe writes and error reporting.
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DEPTH_WORDS  = 256,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst,
  data_memory_ctrl_if.slave   bus,
  output state_t              state_dbg
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH+1)'(4 * DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q;
  logic [1:0]  lane_q;
  logic [2:0]  f3_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_error_q;

  logic [IDX_W-1:0] idx;
  logic             accept;
  logic             req_err;
  logic             load_rsp;
  logic [31:0]      src_word;
  logic [1:0]       src_lane;
  logic [2:0]       src_f3;
  logic [31:0]      ext_rdata;
  logic [31:0]      wdata_rep;
  logic [3:0]       strb;

  assign idx    = bus.req_addr[IDX_W+1:2];
  assign accept = bus.req_valid & bus.req_ready;
  assign strb   = byte_strobe(bus.req_funct3, bus.req_addr[1:0]);

  always_comb begin
    req_err = 1'b0;
    case (bus.req_funct3)
      F3_B:    req_err = 1'b0;
      F3_H:    req_err = bus.req_addr[0];
      F3_W:    req_err = |bus.req_addr[1:0];
      F3_BU:   req_err = bus.req_write;
      F3_HU:   req_err = bus.req_write | bus.req_addr[0];
      default: req_err = 1'b1;
    endcase
    if ({1'b0, bus.req_addr} >= ADDR_LIMIT) req_err = 1'b1;
  end

  // With READ_LATENCY=1 the response is built straight from the RAM at the accept edge.
  always_comb begin
    if (state_q == IDLE) begin
      src_word = mem[idx];
      src_lane = bus.req_addr[1:0];
      src_f3   = bus.req_funct3;
    end else begin
      src_word = word_q;
      src_lane = lane_q;
      src_f3   = f3_q;
    end
  end

  dmem_lane_align u_align (
    .word      (src_word),
    .lane      (src_lane),
    .funct3    (src_f3),
    .wdata     (bus.req_wdata),
    .rdata     (ext_rdata),
    .wdata_rep (wdata_rep)
  );

  // The counter leaves WAIT when it reaches zero, giving READ_LATENCY edges from accept to RESP.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_rsp = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err || bus.req_write) begin
            state_d = RESP;
          end else if (READ_LATENCY == 1) begin
            state_d  = RESP;
            load_rsp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 2'(READ_LATENCY - 1);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          state_d  = RESP;
          load_rsp = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      word_q      <= '0;
      lane_q      <= '0;
      f3_q        <= '0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        word_q      <= mem[idx];
        lane_q      <= bus.req_addr[1:0];
        f3_q        <= bus.req_funct3;
        rsp_error_q <= req_err;
        if (req_err || bus.req_write) rsp_rdata_q <= '0;
      end
      if (load_rsp) rsp_rdata_q <= ext_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && bus.req_write && !req_err) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  assign bus.req_ready = (state_q == IDLE) && !rst;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_error = rsp_error_q;
  assign state_dbg     = state_q;

endmodule
